// File: rtl/idma_mchan_id_tracker.sv
// Multi-channel iDMA frontend: round-robin arbitration onto one backend port with per-channel
// transfer ID tracking. Define IDMA_MCHAN_IRQ_EN to add the per-channel completion pulse ch_irq_o.
module idma_mchan_id_tracker #(
    parameter int unsigned NumChan    = 2,
    parameter int unsigned IdWidth    = 16,
    parameter int unsigned OutstDepth = 8,
    parameter type         req_t      = logic
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  req_t                             ch_req_i [NumChan],
    input  logic [NumChan-1:0]               ch_valid_i,
    output logic [NumChan-1:0]               ch_ready_o,
    output logic [NumChan-1:0][IdWidth-1:0]  ch_next_id_o,
    output logic [NumChan-1:0][IdWidth-1:0]  ch_done_id_o,
    output req_t                             be_req_o,
    output logic                             be_valid_o,
    input  logic                             be_ready_i,
    input  logic                             be_rsp_valid_i,
    output logic                             be_rsp_ready_o,
    output logic                             busy_o
`ifdef IDMA_MCHAN_IRQ_EN
    ,
    output logic [NumChan-1:0]               ch_irq_o
`endif
);
    localparam int unsigned ChW  = (NumChan > 1) ? $clog2(NumChan) : 1;
    localparam int unsigned PtrW = $clog2(OutstDepth);
    localparam int unsigned CntW = PtrW + 1;

    logic [ChW-1:0]                    prio_q, prio_d;
    logic                              lock_q;
    logic [ChW-1:0]                    lock_ch_q;
    logic [PtrW-1:0]                   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]                   count_q, count_d;
    logic [ChW-1:0]                    fifo_q [OutstDepth];
    logic [NumChan-1:0][IdWidth-1:0]   next_id_q, next_id_d;
    logic [NumChan-1:0][IdWidth-1:0]   done_id_q, done_id_d;

    logic [ChW:0]   cand;
    logic [ChW-1:0] rr_ch, gnt_ch, head_ch;
    logic           rr_found, full, issue, retire;

    // Round-robin search starting at the priority pointer.
    always_comb begin
        rr_ch    = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int unsigned i = 0; i < NumChan; i++) begin
            cand = {1'b0, prio_q} + (ChW+1)'(i);
            if (cand >= (ChW+1)'(NumChan)) cand = cand - (ChW+1)'(NumChan);
            if (!rr_found && ch_valid_i[cand[ChW-1:0]]) begin
                rr_found = 1'b1;
                rr_ch    = cand[ChW-1:0];
            end
        end
    end

    // A stalled offer keeps its channel: no re-arbitration until the backend accepts.
    assign gnt_ch         = lock_q ? lock_ch_q : rr_ch;
    assign full           = (count_q == CntW'(OutstDepth));
    assign be_valid_o     = !rst_i && !full && ch_valid_i[gnt_ch];
    assign be_req_o       = ch_req_i[gnt_ch];
    assign be_rsp_ready_o = !rst_i && (count_q != '0);
    assign issue          = be_valid_o && be_ready_i;
    assign retire         = be_rsp_valid_i && be_rsp_ready_o;
    assign head_ch        = fifo_q[rd_ptr_q];
    assign busy_o         = (count_q != '0) || (|ch_valid_i);
    assign ch_next_id_o   = next_id_q;
    assign ch_done_id_o   = done_id_q;

    always_comb begin
        ch_ready_o = '0;
        if (be_valid_o) ch_ready_o[gnt_ch] = be_ready_i;
    end

    always_comb begin
        next_id_d = next_id_q;
        done_id_d = done_id_q;
        count_d   = count_q + CntW'(issue) - CntW'(retire);
        prio_d    = prio_q;
        if (issue) prio_d = (gnt_ch == ChW'(NumChan - 1)) ? '0 : gnt_ch + ChW'(1);
        for (int c = 0; c < NumChan; c++) begin
            if (issue && gnt_ch == ChW'(c))   next_id_d[c] = next_id_q[c] + IdWidth'(1);
            if (retire && head_ch == ChW'(c)) done_id_d[c] = done_id_q[c] + IdWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q    <= '0;
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int c = 0; c < NumChan; c++) begin
                next_id_q[c] <= IdWidth'(1);
                done_id_q[c] <= '0;
            end
        end else begin
            prio_q    <= prio_d;
            lock_q    <= be_valid_o && !be_ready_i;
            lock_ch_q <= gnt_ch;
            count_q   <= count_d;
            next_id_q <= next_id_d;
            done_id_q <= done_id_d;
            if (issue)  wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (retire) rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    // Order storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (issue) fifo_q[wr_ptr_q] <= gnt_ch;
    end

`ifdef IDMA_MCHAN_IRQ_EN
    logic [NumChan-1:0] irq_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q <= '0;
        end else begin
            irq_q <= '0;
            if (retire) irq_q[head_ch] <= 1'b1;
        end
    end

    assign ch_irq_o = irq_q;
`endif

endmodule

// File: tb/tb_idma_mchan_id_tracker.sv
// Self-checking bench for idma_mchan_id_tracker: directed table, corner sequences, and random
// traffic compared against a queue-based reference model.
module tb_idma_mchan_id_tracker;
    localparam int NC = 2;
    localparam int IW = 4;
    localparam int OD = 8;
    typedef logic [7:0] req_t;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    req_t                       ch_req [NC];
    logic [NC-1:0]              ch_valid = '0;
    logic [NC-1:0]              ch_ready;
    logic [NC-1:0][IW-1:0]      next_id, done_id;
    req_t                       be_req;
    logic                       be_valid, be_ready = 1'b0, rsp_valid = 1'b0, rsp_ready, busy;
`ifdef IDMA_MCHAN_IRQ_EN
    logic [NC-1:0]              irq;
`endif

    always #5 clk = ~clk;

    idma_mchan_id_tracker #(
        .NumChan(NC), .IdWidth(IW), .OutstDepth(OD), .req_t(req_t)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ch_req_i       (ch_req),
        .ch_valid_i     (ch_valid),
        .ch_ready_o     (ch_ready),
        .ch_next_id_o   (next_id),
        .ch_done_id_o   (done_id),
        .be_req_o       (be_req),
        .be_valid_o     (be_valid),
        .be_ready_i     (be_ready),
        .be_rsp_valid_i (rsp_valid),
        .be_rsp_ready_o (rsp_ready),
        .busy_o         (busy)
`ifdef IDMA_MCHAN_IRQ_EN
        ,
        .ch_irq_o       (irq)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: outstanding channel order, per-channel ID counters, arbitration pointer.
    logic [7:0]    exp_q [$];
    int            m_next [NC];
    int            m_done [NC];
    int            m_prio;
    bit            m_held;
    int            m_held_ch;
    logic [NC-1:0] m_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int c = 0; c < NC; c++) begin
            m_next[c] = 1;
            m_done[c] = 0;
        end
        m_prio = 0;
        m_held = 0;
        m_held_ch = 0;
        m_irq = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; ch_valid = '1; be_ready = 1'b1; rsp_valid = 1'b1;
        @(negedge clk);
        check("rst_be_valid", be_valid, 0);
        check("rst_ch_ready", ch_ready, 0);
        check("rst_rsp_ready", rsp_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0; ch_valid = '0; be_ready = 1'b0; rsp_valid = 1'b0;
        model_reset();
    endtask

    // One clock of stimulus; outputs are compared to the model mid-cycle, then the model advances.
    task automatic cycle(input logic [NC-1:0] v, input req_t p0, input req_t p1,
                         input logic rdy, input logic rsp, output int acc_ch);
        int g, c, full_m, ev, ret;
        @(posedge clk);
        #1;
        ch_valid = v; ch_req[0] = p0; ch_req[1] = p1; be_ready = rdy; rsp_valid = rsp;
        @(negedge clk);
        g = -1;
        if (m_held) g = m_held_ch;
        else
            for (int k = 0; k < NC; k++) begin
                c = (m_prio + k) % NC;
                if (g < 0 && v[c]) g = c;
            end
        full_m = (exp_q.size() >= OD);
        ev = (!full_m && g >= 0 && v[g]) ? 1 : 0;
        check("be_valid", be_valid, ev);
        if (ev != 0) check("be_req", be_req, (g == 0) ? p0 : p1);
        check("ch_ready", ch_ready, (ev != 0 && rdy) ? (1 << g) : 0);
        check("rsp_ready", rsp_ready, exp_q.size() != 0);
        check("busy", busy, (exp_q.size() != 0) || (v != 0));
        for (int k = 0; k < NC; k++) begin
            check("next_id", next_id[k], m_next[k]);
            check("done_id", done_id[k], m_done[k]);
        end
`ifdef IDMA_MCHAN_IRQ_EN
        check("irq", irq, m_irq);
`endif
        acc_ch = -1;
        m_irq = '0;
        ret = (rsp && exp_q.size() != 0) ? 1 : 0;
        if (ret != 0) begin
            c = int'(exp_q.pop_front());
            m_done[c] = (m_done[c] + 1) % (1 << IW);
            m_irq[c] = 1'b1;
        end
        if (ev != 0 && rdy) begin
            exp_q.push_back(8'(g));
            m_next[g] = (m_next[g] + 1) % (1 << IW);
            m_prio = (g + 1) % NC;
            acc_ch = g;
        end
        m_held = (ev != 0 && !rdy);
        m_held_ch = (g < 0) ? 0 : g;
    endtask

    typedef struct {
        logic [1:0] v;
        logic       rdy;
        logic       rsp;
        logic       exp_bv;
        logic [1:0] exp_crdy;
        logic       exp_rrdy;
        int         exp_n0, exp_n1, exp_d0, exp_d1;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int acc, n_acc;
        logic [NC-1:0] pend;
        req_t pay [NC];

        ch_req[0] = '0; ch_req[1] = '0;
        model_reset();

        tbl[0] = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1, 1, 0, 0};
        tbl[1] = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 2, 1, 0, 0};
        tbl[2] = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 2, 2, 0, 0};
        tbl[3] = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 3, 2, 0, 0};
        tbl[4] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 3, 3, 0, 0};
        tbl[5] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 3, 3, 1, 0};
        tbl[6] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 3, 3, 1, 1};
        tbl[7] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 3, 3, 2, 1};
        tbl[8] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 3, 3, 2, 2};

        // Reset and idle state.
        do_reset();
        cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, acc);
        check("idle_next0", next_id[0], 1);
        check("idle_next1", next_id[1], 1);
        check("idle_done0", done_id[0], 0);
        check("idle_done1", done_id[1], 0);
        check("idle_busy", busy, 0);
        check("idle_be_valid", be_valid, 0);

        // Alternating grants, then in-order retires.
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].v, 8'hA0, 8'hB1, tbl[i].rdy, tbl[i].rsp, acc);
            check("tbl_be_valid", be_valid, tbl[i].exp_bv);
            check("tbl_ch_ready", ch_ready, tbl[i].exp_crdy);
            check("tbl_rsp_ready", rsp_ready, tbl[i].exp_rrdy);
            check("tbl_next0", next_id[0], tbl[i].exp_n0);
            check("tbl_next1", next_id[1], tbl[i].exp_n1);
            check("tbl_done0", done_id[0], tbl[i].exp_d0);
            check("tbl_done1", done_id[1], tbl[i].exp_d1);
        end

        // Fill the order FIFO; a retire frees space only from the following cycle.
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(2'b01, req_t'(8'h40 + n_acc), 8'h00, 1'b1, 1'b0, acc);
            if (acc >= 0) n_acc++;
        end
        check("full_accepted", n_acc, OD);
        check("full_be_valid", be_valid, 0);
        check("full_ch_ready", ch_ready, 0);
        cycle(2'b01, req_t'(8'h40 + n_acc), 8'h00, 1'b1, 1'b1, acc);
        check("full_retire_same_cycle_valid", be_valid, 0);
        cycle(2'b01, req_t'(8'h40 + n_acc), 8'h00, 1'b1, 1'b0, acc);
        check("full_ninth_valid", be_valid, 1);
        check("full_ninth_ready", ch_ready, 2'b01);
        check("full_done0", done_id[0], 1);

        // Stalled ch0 offer holds while ch1 raises valid.
        do_reset();
        cycle(2'b01, 8'h11, 8'h22, 1'b0, 1'b0, acc);
        for (int i = 0; i < 2; i++) begin
            cycle(2'b11, 8'h11, 8'h22, 1'b0, 1'b0, acc);
            check("stall_hold_ch0", be_req, 8'h11);
        end
        cycle(2'b11, 8'h11, 8'h22, 1'b1, 1'b0, acc);
        check("stall_accept_ch0", acc, 0);
        cycle(2'b10, 8'h11, 8'h22, 1'b0, 1'b0, acc);
        check("stall_then_ch1", be_req, 8'h22);

        // Stalled ch1 offer is not pre-empted by higher-priority ch0.
        do_reset();
        cycle(2'b10, 8'h33, 8'h44, 1'b0, 1'b0, acc);
        cycle(2'b11, 8'h33, 8'h44, 1'b0, 1'b0, acc);
        check("stall_hold_ch1", be_req, 8'h44);
        cycle(2'b11, 8'h33, 8'h44, 1'b1, 1'b0, acc);
        check("stall_accept_ch1", acc, 1);
        cycle(2'b01, 8'h33, 8'h44, 1'b1, 1'b0, acc);
        check("stall_then_ch0", acc, 0);

        // ID wrap on ch0 with simultaneous issue and retire.
        do_reset();
        for (int i = 0; i < 16; i++) cycle(2'b01, req_t'(i), 8'h00, 1'b1, 1'b1, acc);
        cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, acc);
        cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, acc);
        check("wrap_next0", next_id[0], 1);
        check("wrap_done0", done_id[0], 0);
        check("wrap_next1", next_id[1], 1);

        // Random traffic with a mid-run reset discarding outstanding work.
        do_reset();
        pend = '0;
        pay[0] = '0; pay[1] = '0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
                pend = '0;
            end
            for (int c = 0; c < NC; c++)
                if (!pend[c] && $urandom_range(0, 2) == 0) begin
                    pend[c] = 1'b1;
                    pay[c] = req_t'($urandom);
                end
            cycle(pend, pay[0], pay[1], $urandom_range(0, 3) != 0,
                  (i % 500 < 250) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0), acc);
            if (acc >= 0) pend[acc] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/idma_mchan_id_tracker.md
IDMA_MCHAN_ID_TRACKER -- requirements
Module: idma_mchan_id_tracker

Interface
- REQ-001: Parameter NumChan, default 2: number of frontend request channels (1..16).
- REQ-002: Parameter IdWidth, default 16: per-channel transfer ID counter width.
- REQ-003: Parameter OutstDepth, default 8: maximum outstanding transfers across all channels (power of two, 2..64).
- REQ-004: Parameter req_t, default logic: opaque transfer request type, forwarded unmodified.
- REQ-005: Port clk_i, input, 1: single clock; all state on rising edge.
- REQ-006: Port rst_i, input, 1: reset, synchronous and active-high.
- REQ-007: Port ch_req_i, input, NumChan x req_t: per-channel request payload.
- REQ-008: Port ch_valid_i / ch_ready_o, input / output, NumChan each: per-channel request handshake.
- REQ-009: Port ch_next_id_o, output, NumChan x IdWidth: ID the channel's next accepted transfer receives.
- REQ-010: Port ch_done_id_o, output, NumChan x IdWidth: ID of the channel's last retired transfer.
- REQ-011: Port be_req_o / be_valid_o / be_ready_i, output / output / input, req_t / 1 / 1: backend request handshake.
- REQ-012: Port be_rsp_valid_i / be_rsp_ready_o, input / output, 1 / 1: backend completion handshake, one per accepted transfer, in issue order.
- REQ-013: Port busy_o, output, 1: high while any transfer is pending or outstanding.
- REQ-014: Port ch_irq_o, output, NumChan: per-channel completion pulse (present only with IDMA_MCHAN_IRQ_EN, see Configuration).

Function
- REQ-015: Round-robin arbitration over channels with ch_valid_i high; priority pointer starts at channel 0 and moves to (granted+1) mod NumChan on each backend handshake.
- REQ-016: Once be_valid_o rises, grant and be_req_o SHALL stay stable until be_ready_i; no re-arbitration while stalled.
- REQ-017: ch_ready_o[g] = be_ready_i for granted channel g only; all other ch_ready_o low; combinational pass-through, zero-cycle latency.
- REQ-018: Issue (be_valid_o & be_ready_i) SHALL push granted channel index into an OutstDepth-entry order FIFO and increment ch_next_id_o[g] by 1, wrapping 2^IdWidth-1 -> 0.
- REQ-019: When order FIFO is full, be_valid_o and all ch_ready_o SHALL be low; fullness uses the registered count (no same-cycle bypass from a retire).
- REQ-020: be_rsp_ready_o = order FIFO non-empty; be_rsp_valid_i while empty is ignored.
- REQ-021: Retire (be_rsp_valid_i & be_rsp_ready_o) SHALL pop the FIFO head c and increment ch_done_id_o[c] by 1 with the same wrap rule.
- REQ-022: Simultaneous issue and retire in one cycle SHALL both take effect; count unchanged; if same channel, both its counters increment.
- REQ-023: busy_o = (count != 0) | (|ch_valid_i).
- REQ-024: Per-channel counters independent; retires are strictly in FIFO order regardless of channel.

Reset
- REQ-025: On rst_i high at a clock edge: ch_next_id_o = 1, ch_done_id_o = 0, FIFO empty, priority pointer 0, ch_irq_o = 0.
- REQ-026: While rst_i is high: be_valid_o, all ch_ready_o, be_rsp_ready_o low; outstanding transfers are discarded (no retire credited).

Configuration
- REQ-027: Macro IDMA_MCHAN_IRQ_EN defined: ch_irq_o[c] is a registered one-cycle pulse in the cycle after each retire of channel c.
- REQ-028: Macro IDMA_MCHAN_IRQ_EN undefined: ch_irq_o port and its registers are absent; all other behaviour identical.

Verification
- REQ-029: Reset, NumChan=2, idle -> ch_next_id_o={1,1}, ch_done_id_o={0,0}, busy_o=0, be_valid_o=0.
- REQ-030: Both channels valid, be_ready_i=1, 4 cycles -> grants 0,1,0,1; next_id={3,3}; FIFO holds 0,1,0,1.
- REQ-031: OutstDepth=8, no responses, 10 requests offered on ch0 -> 8 accepted, be_valid_o low afterwards; one response -> done_id[0]=1, ninth accepted next cycle.
- REQ-032: be_ready_i low 3 cycles with ch0 granted, ch1 raises valid -> be_req_o remains ch0 payload until handshake, then ch1 granted.
- REQ-033: IdWidth=4, 16 issues and retires on ch0 -> next_id wraps 15->0->1, done_id reaches 0 after 16th retire.
- REQ-034: IDMA_MCHAN_IRQ_EN defined, retire of ch1 at cycle N -> ch_irq_o=2'b10 in cycle N+1 only; undefined build elaborates without ch_irq_o.
